// File: rtl/sprite_line_renderer.sv
// -----------------------------------------------------------------------------
// sprite_line_renderer
//   Per-scanline sprite fetch and pixel generation. When line_start marks the
//   start of horizontal blank, the block walks every entity slot once, decides
//   whether that slot's sprite covers the next scanline, and captures the
//   matching 8-pixel ROM row, the sprite's x position and a hit flag. During
//   the active region it compares hpos against the captured sprites and emits
//   a registered pixel_on / pixel_slot pair (lowest slot index wins).
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   hpos, vpos          current pixel column / line from the sync generator
//   line_start          1-cycle pulse at the start of hblank
//   slot_sel            slot currently being queried (entity_* reply same cycle)
//   entity_valid/id/orient/x/y   attributes of the selected slot
//   rom_read_enable, rom_sprite_ID, rom_orientation, rom_line_index
//                       combinational ROM request, zero outside a fetch
//   rom_data            ROM row reply, active-low, MSB = leftmost pixel
//   pixel_on, pixel_slot  registered pixel result for the previous hpos
//   busy                high while slots are being fetched
// -----------------------------------------------------------------------------
module sprite_line_renderer #(
    parameter int NUM_SLOTS  = 4,
    parameter int SCALE_LOG2 = 2,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int V_LAST     = 524,
    localparam int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        hpos,
    input  logic [9:0]        vpos,
    input  logic              line_start,
    output logic [SLOT_W-1:0] slot_sel,
    input  logic              entity_valid,
    input  logic [3:0]        entity_id,
    input  logic [1:0]        entity_orient,
    input  logic [9:0]        entity_x,
    input  logic [9:0]        entity_y,
    output logic              rom_read_enable,
    output logic [3:0]        rom_sprite_ID,
    output logic [1:0]        rom_orientation,
    output logic [2:0]        rom_line_index,
    input  logic [7:0]        rom_data,
    output logic              pixel_on,
    output logic [SLOT_W-1:0] pixel_slot,
    output logic              busy
);

    localparam logic [9:0]        SPRITE_PX = 10'(8 << SCALE_LOG2);
    localparam logic [9:0]        H_LIM     = 10'(H_ACTIVE);
    localparam logic [9:0]        V_LIM     = 10'(V_ACTIVE);
    localparam logic [9:0]        V_END     = 10'(V_LAST);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t                  state;
    logic [9:0]              next_line;
    logic [NUM_SLOTS-1:0]    hit_buf;
    logic [7:0]              row_buf [NUM_SLOTS];
    logic [9:0]              xs_buf  [NUM_SLOTS];

    logic                    in_fetch;
    logic [9:0]              dy;
    logic                    fetch_hit;
    logic                    any_on;
    logic [SLOT_W-1:0]       win_slot;
    logic                    active;

    // Fetch-side request: distance of the next line below the sprite top.
    // A sprite that starts below the next line wraps dy to a large value and
    // therefore never hits.
    always_comb begin
        in_fetch        = (state == FETCH);
        dy              = next_line - entity_y;
        fetch_hit       = in_fetch && entity_valid && (dy < SPRITE_PX);
        rom_read_enable = fetch_hit;
        if (in_fetch) begin
            rom_sprite_ID   = entity_id;
            rom_orientation = entity_orient;
            rom_line_index  = dy[SCALE_LOG2 +: 3];
        end else begin
            rom_sprite_ID   = 4'd0;
            rom_orientation = 2'd0;
            rom_line_index  = 3'd0;
        end
    end

    // Fetch FSM: slot walk, line buffer capture, busy and slot_sel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            slot_sel  <= '0;
            busy      <= 1'b0;
            next_line <= 10'd0;
            hit_buf   <= '0;
            for (int k = 0; k < NUM_SLOTS; k++) begin
                row_buf[k] <= 8'hFF;
                xs_buf[k]  <= 10'd0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (line_start) begin
                        state     <= FETCH;
                        busy      <= 1'b1;
                        slot_sel  <= '0;
                        next_line <= (vpos == V_END) ? 10'd0 : vpos + 10'd1;
                    end else begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        slot_sel <= '0;
                    end
                end
                FETCH: begin
                    // line_start is deliberately ignored here
                    row_buf[slot_sel] <= rom_data;
                    xs_buf[slot_sel]  <= entity_x;
                    hit_buf[slot_sel] <= fetch_hit;
                    if (slot_sel == LAST_SLOT) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        slot_sel <= '0;
                    end else begin
                        state    <= FETCH;
                        busy     <= 1'b1;
                        slot_sel <= slot_sel + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    slot_sel <= '0;
                end
            endcase
        end
    end

    // Pixel search: walk slots from highest to lowest so the lowest
    // covering slot is the one left in win_slot.
    always_comb begin
        logic [9:0] dx;
        logic [2:0] col;
        logic       on;
        any_on   = 1'b0;
        win_slot = '0;
        dx       = 10'd0;
        col      = 3'd0;
        on       = 1'b0;
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            dx       = hpos - xs_buf[k];
            col      = dx[SCALE_LOG2 +: 3];
            on       = hit_buf[k] && (dx < SPRITE_PX) && !row_buf[k][3'd7 - col];
            any_on   = any_on | on;
            win_slot = on ? SLOT_W'(k) : win_slot;
        end
        active = (hpos < H_LIM) && (vpos < V_LIM);
    end

    // Registered pixel output; blanking forces it off and the slot to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_on   <= 1'b0;
            pixel_slot <= '0;
        end else begin
            pixel_on   <= any_on && active;
            pixel_slot <= (any_on && active) ? win_slot : '0;
        end
    end

endmodule

// File: tb/tb_sprite_line_renderer.sv
module tb_sprite_line_renderer;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] hpos, vpos;
    logic       line_start;
    logic [1:0] slot_sel;
    logic       entity_valid;
    logic [3:0] entity_id;
    logic [1:0] entity_orient;
    logic [9:0] entity_x, entity_y;
    logic       rom_read_enable;
    logic [3:0] rom_sprite_ID;
    logic [1:0] rom_orientation;
    logic [2:0] rom_line_index;
    logic [7:0] rom_data;
    logic       pixel_on;
    logic [1:0] pixel_slot;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // entity table, answered combinationally from slot_sel
    logic       ev  [4];
    logic [3:0] eid [4];
    logic [1:0] eor [4];
    logic [9:0] ex  [4];
    logic [9:0] ey  [4];

    // per-fetch-cycle capture
    logic       re_log   [4];
    logic [2:0] li_log   [4];
    logic [3:0] id_log   [4];
    logic [1:0] or_log   [4];
    logic [1:0] sel_log  [4];
    logic       busy_log [4];
    logic       end_busy;

    assign entity_valid  = ev[slot_sel];
    assign entity_id     = eid[slot_sel];
    assign entity_orient = eor[slot_sel];
    assign entity_x      = ex[slot_sel];
    assign entity_y      = ey[slot_sel];

    // ROM model: heart (id0, UP) row 1 lights columns 1,2,5,6; sword (id1) rows fully lit
    assign rom_data = (rom_sprite_ID == 4'd0 && rom_orientation == 2'd0 && rom_line_index == 3'd1) ? 8'h99 :
                      (rom_sprite_ID == 4'd1) ? 8'h00 : 8'hFF;

    always #5 clk = ~clk;

    sprite_line_renderer dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .line_start(line_start),
        .slot_sel(slot_sel), .entity_valid(entity_valid), .entity_id(entity_id),
        .entity_orient(entity_orient), .entity_x(entity_x), .entity_y(entity_y),
        .rom_read_enable(rom_read_enable), .rom_sprite_ID(rom_sprite_ID),
        .rom_orientation(rom_orientation), .rom_line_index(rom_line_index),
        .rom_data(rom_data), .pixel_on(pixel_on), .pixel_slot(pixel_slot), .busy(busy)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_slots();
        for (int i = 0; i < 4; i++) begin
            ev[i] = 1'b0; eid[i] = 4'd0; eor[i] = 2'd0; ex[i] = 10'd0; ey[i] = 10'd0;
        end
    endtask

    task automatic set_slot(input int i, input logic [3:0] id, input logic [1:0] o,
                            input logic [9:0] x, input logic [9:0] y);
        ev[i] = 1'b1; eid[i] = id; eor[i] = o; ex[i] = x; ey[i] = y;
    endtask

    // pulse line_start in hblank and log the four fetch cycles;
    // extra=1 raises a second line_start while the fetch is running
    task automatic fetch(input logic [9:0] v, input logic extra);
        vpos = v; hpos = 10'd640; line_start = 1'b1;
        @(posedge clk); #1;
        line_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            re_log[k] = rom_read_enable; li_log[k] = rom_line_index;
            id_log[k] = rom_sprite_ID;   or_log[k] = rom_orientation;
            sel_log[k] = slot_sel;       busy_log[k] = busy;
            line_start = (extra && k == 0) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            line_start = 1'b0;
        end
        end_busy = busy;
    endtask

    // sweep hpos on line v; pixel expected on in [lo1,hi1] or [lo2,hi2]
    task automatic sweep(input string tag, input logic [9:0] v, input int h0, input int h1,
                         input int lo1, input int hi1, input int lo2, input int hi2,
                         input logic [1:0] es);
        logic e;
        for (int h = h0; h <= h1; h++) begin
            hpos = 10'(h); vpos = v;
            @(posedge clk); #1;
            e = ((h >= lo1) && (h <= hi1)) || ((h >= lo2) && (h <= hi2));
            chk($sformatf("%s_on_h%0d", tag, h), {15'd0, pixel_on}, {15'd0, e});
            chk($sformatf("%s_slot_h%0d", tag, h), {14'd0, pixel_slot}, e ? {14'd0, es} : 16'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_slots();
        reset = 1'b1; line_start = 1'b0; hpos = 10'd0; vpos = 10'd0;
        #12;
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_slot_sel", {14'd0, slot_sel}, 16'd0);
        chk("rst_rom_re", {15'd0, rom_read_enable}, 16'd0);
        chk("rst_rom_line", {13'd0, rom_line_index}, 16'd0);
        chk("rst_pixel_on", {15'd0, pixel_on}, 16'd0);
        chk("rst_pixel_slot", {14'd0, pixel_slot}, 16'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // heart on slot 0, fetched on line 49 for line 50 (row 1)
        set_slot(0, 4'd0, 2'd0, 10'd100, 10'd46);
        fetch(10'd49, 1'b0);
        chk("heart_re0", {15'd0, re_log[0]}, 16'd1);
        chk("heart_line0", {13'd0, li_log[0]}, 16'd1);
        chk("heart_id0", {12'd0, id_log[0]}, 16'd0);
        chk("heart_re1", {15'd0, re_log[1]}, 16'd0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("heart_sel%0d", k), {14'd0, sel_log[k]}, 16'(k));
            chk($sformatf("heart_busy%0d", k), {15'd0, busy_log[k]}, 16'd1);
        end
        chk("heart_busy_end", {15'd0, end_busy}, 16'd0);
        sweep("heart", 10'd50, 95, 135, 104, 111, 120, 127, 2'd0);

        // two swords on slots 0 and 1 at the same place: slot 0 wins
        clear_slots();
        set_slot(0, 4'd1, 2'd2, 10'd200, 10'd40);
        set_slot(1, 4'd1, 2'd2, 10'd200, 10'd40);
        fetch(10'd49, 1'b0);
        chk("sword_re0", {15'd0, re_log[0]}, 16'd1);
        chk("sword_re1", {15'd0, re_log[1]}, 16'd1);
        chk("sword_re2", {15'd0, re_log[2]}, 16'd0);
        chk("sword_line1", {13'd0, li_log[1]}, 16'd2);
        chk("sword_orient0", {14'd0, or_log[0]}, 16'd2);
        chk("sword_id1", {12'd0, id_log[1]}, 16'd1);
        sweep("sword01", 10'd50, 196, 235, 200, 231, 1, 0, 2'd0);
        ev[0] = 1'b0;
        fetch(10'd49, 1'b0);
        sweep("sword1", 10'd50, 196, 235, 200, 231, 1, 0, 2'd1);

        // last line of the frame fetches row 0 for line 0
        clear_slots();
        set_slot(0, 4'd1, 2'd0, 10'd10, 10'd0);
        fetch(10'd524, 1'b0);
        chk("wrap_re0", {15'd0, re_log[0]}, 16'd1);
        chk("wrap_line0", {13'd0, li_log[0]}, 16'd0);
        sweep("wrap", 10'd0, 6, 45, 10, 41, 1, 0, 2'd0);

        // sprite starting below the next line never hits
        ey[0] = 10'd60;
        fetch(10'd49, 1'b0);
        for (int k = 0; k < 4; k++)
            chk($sformatf("below_re%0d", k), {15'd0, re_log[k]}, 16'd0);
        sweep("below", 10'd50, 6, 45, 1, 0, 1, 0, 2'd0);

        // reset asserted in fetch cycle 2 aborts the fetch
        clear_slots();
        for (int i = 0; i < 4; i++) set_slot(i, 4'd0, 2'd0, 10'd100, 10'd46);
        vpos = 10'd49; hpos = 10'd640; line_start = 1'b1;
        @(posedge clk); #1;
        line_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_sel_before", {14'd0, slot_sel}, 16'd2);
        chk("abort_re_before", {15'd0, rom_read_enable}, 16'd1);
        reset = 1'b1;
        #1;
        chk("abort_busy", {15'd0, busy}, 16'd0);
        chk("abort_re", {15'd0, rom_read_enable}, 16'd0);
        chk("abort_sel", {14'd0, slot_sel}, 16'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        sweep("abort", 10'd50, 98, 130, 1, 0, 1, 0, 2'd0);

        // a second line_start during the fetch is ignored
        clear_slots();
        set_slot(0, 4'd0, 2'd0, 10'd100, 10'd46);
        fetch(10'd49, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("dbl_busy%0d", k), {15'd0, busy_log[k]}, 16'd1);
            chk($sformatf("dbl_sel%0d", k), {14'd0, sel_log[k]}, 16'(k));
        end
        chk("dbl_busy_end", {15'd0, end_busy}, 16'd0);
        @(posedge clk); #1;
        chk("dbl_busy_after", {15'd0, busy}, 16'd0);
        sweep("dbl", 10'd50, 102, 129, 104, 111, 120, 127, 2'd0);

        // sprite at the right edge is clipped; hblank stays dark
        clear_slots();
        set_slot(2, 4'd1, 2'd0, 10'd620, 10'd40);
        fetch(10'd49, 1'b0);
        chk("clip_re2", {15'd0, re_log[2]}, 16'd1);
        sweep("clip", 10'd50, 615, 799, 620, 639, 1, 0, 2'd2);
        // vertical blank keeps everything off
        sweep("vblank", 10'd480, 615, 645, 1, 0, 1, 0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
